// File: rtl/mult_div.sv
// mult_div: multi-cycle signed multiply/divide unit with internal HI/LO.
// Multiply uses radix-2 Booth recoding. Divide uses restoring division on
// operand magnitudes with sign fix-up. Each takes 32 iterations plus one
// FINISH cycle. All outputs are registered.
module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FINISH
  } state_e;

  state_e      state_q, state_d;

  // Shared iteration datapath.
  //   Multiply: {acc, mq, q1} is the Booth register. acc carries one guard
  //   bit so that a multiplicand of 0x80000000 cannot overflow when it is
  //   subtracted.
  //   Divide:   acc[31:0] holds the partial remainder and mq holds the
  //   dividend bits, which shift out as quotient bits shift in.
  logic [32:0] acc_q, acc_d;
  logic [31:0] mq_q, mq_d;
  logic        q1_q, q1_d;
  logic [32:0] m_q, m_d;        // sign-extended multiplicand, or |divisor|
  logic [4:0]  cnt_q, cnt_d;

  // Operation bookkeeping used in FINISH.
  logic        is_div_q, is_div_d;
  logic        zero_q, zero_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  // Registered outputs.
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  // Datapath scratch values.
  logic [32:0] booth_sum;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // Next-state, iteration and result logic.
  always_comb begin
    // NOTE: every signal written here gets a default first. Without the
    // defaults, any path that skips an assignment would infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    q1_d       = q1_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    zero_d     = zero_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    booth_sum  = acc_q;
    rem_sh     = {acc_q[31:0], mq_q[31]};
    trial      = rem_sh - m_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          // Multiply wins when both requests arrive together.
          m_d      = {a[31], a};
          mq_d     = b;
          acc_d    = '0;
          q1_d     = 1'b0;
          cnt_d    = '0;
          is_div_d = 1'b0;
          zero_d   = 1'b0;
          state_d  = S_MULT;
        end else if (start_div) begin
          is_div_d = 1'b1;
          cnt_d    = '0;
          if (b == 32'd0) begin
            zero_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            zero_d    = 1'b0;
            acc_d     = '0;
            mq_d      = abs_a;
            m_d       = {1'b0, abs_b};
            neg_quo_d = a[31] ^ b[31];
            neg_rem_d = a[31];
            state_d   = S_DIV;
          end
        end
      end

      S_MULT: begin
        unique case ({mq_q[0], q1_q})
          2'b01:   booth_sum = acc_q + m_q;
          2'b10:   booth_sum = acc_q - m_q;
          default: booth_sum = acc_q;
        endcase
        // Arithmetic right shift of the whole Booth register.
        acc_d = {booth_sum[32], booth_sum[32:1]};
        mq_d  = {booth_sum[0], mq_q[31:1]};
        q1_d  = mq_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FINISH;
      end

      S_DIV: begin
        // Shift the next dividend bit into the remainder, then try the
        // subtraction. The trial sign says whether it succeeded. The
        // remainder stays below |divisor| <= 2^31, so bit 32 is a true sign.
        if (trial[32]) begin
          acc_d = {1'b0, rem_sh[31:0]};
        end else begin
          acc_d = {1'b0, trial[31:0]};
        end
        mq_d  = {mq_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DIV == S_DIV ? S_FINISH : S_FINISH;
      end

      S_FINISH: begin
        state_d = S_IDLE;
        if (!is_div_q) begin
          hi_d = acc_q[31:0];
          lo_d = mq_q;
        end else if (!zero_q) begin
          // Negating the unsigned quotient 0x80000000 gives 0x80000000 back.
          // That is the required result for 0x80000000 / -1.
          lo_d = neg_quo_q ? (32'd0 - mq_q) : mq_q;
          hi_d = neg_rem_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_FINISH);
    div_zero_d = (state_q == S_FINISH) && is_div_q && zero_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every flop updating from pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      mq_q       <= '0;
      q1_q       <= 1'b0;
      m_q        <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      zero_q     <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      q1_q       <= q1_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      zero_q     <= zero_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed self-checking bench for mult_div.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_checks = 0;
  int n_errors = 0;

  mult_div dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request at E0 and waits for done (bounded).
  // lat is the number of edges from E0 to done, or -1 on timeout.
  task automatic run_op(input logic sm, input logic sd, input logic [31:0] oa,
                        input logic [31:0] ob, output int lat, output logic dz,
                        output logic bz);
    start_mult = sm;
    start_div  = sd;
    a          = oa;
    b          = ob;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = $urandom;
    b          = $urandom;
    bz         = busy;
    lat        = -1;
    dz         = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        dz  = div_zero;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic dz;
    logic bz;
    int   done_cnt;
    int   done_at;
    logic dz_seen;
    logic [31:0] hi_at;
    logic [31:0] lo_at;

    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    reset = 1'b0;

    // 7 * -3 = -21
    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, lat, dz, bz);
    check("m1_busy_e0", bz, 1);
    check("m1_lat", lat, 33);
    check("m1_hi", hi, 64'hFFFF_FFFF);
    check("m1_lo", lo, 64'hFFFF_FFEB);
    check("m1_busy_done", busy, 0);
    check("m1_dz", dz, 0);
    @(posedge clk);
    #1;
    check("m1_done_pulse", done, 0);
    check("m1_hold_lo", lo, 64'hFFFF_FFEB);

    // (-2^31) * (-2^31) = 2^62
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, lat, dz, bz);
    check("m2_lat", lat, 33);
    check("m2_hi", hi, 64'h4000_0000);
    check("m2_lo", lo, 64'h0);

    // Both requests together: multiply wins. 6 * -2 = -12
    run_op(1, 1, 32'd6, 32'hFFFF_FFFE, lat, dz, bz);
    check("both_lat", lat, 33);
    check("both_hi", hi, 64'hFFFF_FFFF);
    check("both_lo", lo, 64'hFFFF_FFF4);
    check("both_dz", dz, 0);

    // -7 / 2 = -3 remainder -1
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, lat, dz, bz);
    check("d1_busy_e0", bz, 1);
    check("d1_lat", lat, 33);
    check("d1_lo", lo, 64'hFFFF_FFFD);
    check("d1_hi", hi, 64'hFFFF_FFFF);

    // 7 / -2 = -3 remainder 1
    run_op(0, 1, 32'd7, 32'hFFFF_FFFE, lat, dz, bz);
    check("d2_lo", lo, 64'hFFFF_FFFD);
    check("d2_hi", hi, 64'h1);

    // Overflow case: 0x80000000 / -1
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, lat, dz, bz);
    check("d3_lat", lat, 33);
    check("d3_lo", lo, 64'h8000_0000);
    check("d3_hi", hi, 64'h0);
    check("d3_dz", dz, 0);

    // 100 / 0: quick finish, HI/LO unchanged
    run_op(0, 1, 32'd100, 32'd0, lat, dz, bz);
    check("dz_busy_e0", bz, 1);
    check("dz_lat", lat, 1);
    check("dz_flag", dz, 1);
    check("dz_lo_kept", lo, 64'h8000_0000);
    check("dz_hi_kept", hi, 64'h0);
    @(posedge clk);
    #1;
    check("dz_flag_pulse", div_zero, 0);
    check("dz_done_pulse", done, 0);

    // Multiply 5*6 with a divide-by-zero request pulsed mid-operation.
    start_mult = 1'b1;
    a          = 32'd5;
    b          = 32'd6;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    done_cnt   = 0;
    done_at    = -1;
    dz_seen    = 1'b0;
    hi_at      = '0;
    lo_at      = '0;
    for (int n = 1; n <= 45; n++) begin
      start_div = (n == 5);
      a         = (n == 5) ? 32'd100 : 32'd0;
      b         = 32'd0;
      @(posedge clk);
      #1;
      start_div = 1'b0;
      if (div_zero) dz_seen = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          hi_at   = hi;
          lo_at   = lo;
        end
      end
    end
    check("ign_done_count", done_cnt, 1);
    check("ign_done_at", done_at, 33);
    check("ign_lo", lo_at, 64'd30);
    check("ign_hi", hi_at, 64'd0);
    check("ign_no_dz", dz_seen, 0);

    // Divide 1000/7, reset after iteration 10.
    start_div = 1'b1;
    a         = 32'd1000;
    b         = 32'd7;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rd_busy_mid", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rd_hi", hi, 0);
    check("rd_lo", lo, 0);
    check("rd_busy", busy, 0);
    check("rd_done", done, 0);
    check("rd_dz", div_zero, 0);

    // 3 * 4 after the reset
    run_op(1, 0, 32'd3, 32'd4, lat, dz, bz);
    check("m3_lat", lat, 33);
    check("m3_lo", lo, 64'd12);
    check("m3_hi", hi, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
